// File: rtl/adaptive_fir.sv
// Three-tap adaptive FIR datapath: tap delay line, Q1.15 filter output and
// saturated estimation error, with an error-aligned tap snapshot for the LMS updater.
module adaptive_fir #(
    parameter int NB_DATA = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_valid,
    input  logic                      i_flush,
    input  logic signed [NB_DATA-1:0] i_x,
    input  logic signed [NB_DATA-1:0] i_d,
    input  logic signed [NB_DATA-1:0] i_h0,
    input  logic signed [NB_DATA-1:0] i_h1,
    input  logic signed [NB_DATA-1:0] i_h2,
    output logic                      o_valid,
    output logic signed [NB_DATA-1:0] o_y,
    output logic signed [NB_DATA-1:0] o_error,
    output logic signed [NB_DATA-1:0] o_x0,
    output logic signed [NB_DATA-1:0] o_x1,
    output logic signed [NB_DATA-1:0] o_x2
);

    localparam int NB_PROD  = 2 * NB_DATA;
    localparam int NB_TRUNC = NB_DATA + 1;
    localparam int NB_SUM   = NB_DATA + 2;
    localparam int NB_DIFF  = NB_DATA + 1;
    localparam logic signed [NB_DATA-1:0] SAT_MAX = {1'b0, {(NB_DATA-1){1'b1}}};
    localparam logic signed [NB_DATA-1:0] SAT_MIN = {1'b1, {(NB_DATA-1){1'b0}}};

    // Clamp a value of up to NB_SUM bits into NB_DATA bits; the value fits
    // exactly when every bit above the Q1.15 sign bit repeats that sign bit.
    function automatic logic signed [NB_DATA-1:0] f_sat(input logic signed [NB_SUM-1:0] v);
        logic [NB_SUM-NB_DATA:0] top;
        top = v[NB_SUM-1:NB_DATA-1];
        if ((&top) || !(|top)) return v[NB_DATA-1:0];
        return v[NB_SUM-1] ? SAT_MIN : SAT_MAX;
    endfunction

    // Stage 0: tap delay line and warm-up counter
    logic signed [NB_DATA-1:0] r_x0, r_x1, r_x2, r_d0;
    logic        [1:0]         r_fill;
    logic                      r_v0;
    logic        [1:0]         w_fill_next;

    assign w_fill_next = (r_fill == 2'd3) ? 2'd3 : r_fill + 2'd1;

    // NOTE: every pipeline register, outputs included, sits on the async reset so
    // o_valid drops the moment i_rst_n falls, not at the next clock edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x0   <= '0;
            r_x1   <= '0;
            r_x2   <= '0;
            r_d0   <= '0;
            r_fill <= '0;
            r_v0   <= 1'b0;
        end else if (i_flush) begin
            r_x0   <= '0;
            r_x1   <= '0;
            r_x2   <= '0;
            r_fill <= '0;
            r_v0   <= 1'b0;
        end else if (i_valid) begin
            r_x0   <= i_x;
            r_x1   <= r_x0;
            r_x2   <= r_x1;
            r_d0   <= i_d;
            r_fill <= w_fill_next;
            r_v0   <= (w_fill_next == 2'd3);
        end else begin
            r_v0   <= 1'b0;
        end
    end

    // Stage 1: Q2.30 products truncated toward -inf by dropping 15 LSBs
    logic signed [NB_PROD-1:0]  w_prod0, w_prod1, w_prod2;
    logic signed [NB_TRUNC-1:0] w_trunc0, w_trunc1, w_trunc2;
    logic signed [NB_DATA-1:0]  r_p0, r_p1, r_p2, r_d1, r_s0, r_s1, r_s2;
    logic                       r_v1;

    assign w_prod0  = NB_PROD'(i_h0) * NB_PROD'(r_x0);
    assign w_prod1  = NB_PROD'(i_h1) * NB_PROD'(r_x1);
    assign w_prod2  = NB_PROD'(i_h2) * NB_PROD'(r_x2);
    assign w_trunc0 = w_prod0[NB_PROD-1:NB_DATA-1];
    assign w_trunc1 = w_prod1[NB_PROD-1:NB_DATA-1];
    assign w_trunc2 = w_prod2[NB_PROD-1:NB_DATA-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_p0 <= '0;
            r_p1 <= '0;
            r_p2 <= '0;
            r_d1 <= '0;
            r_s0 <= '0;
            r_s1 <= '0;
            r_s2 <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_p0 <= f_sat(NB_SUM'(w_trunc0));
            r_p1 <= f_sat(NB_SUM'(w_trunc1));
            r_p2 <= f_sat(NB_SUM'(w_trunc2));
            r_d1 <= r_d0;
            r_s0 <= r_x0;
            r_s1 <= r_x1;
            r_s2 <= r_x2;
            r_v1 <= r_v0 && !i_flush;
        end
    end

    // Stage 2: accumulate, form error, present the aligned snapshot
    logic signed [NB_SUM-1:0]  w_sum;
    logic signed [NB_DATA-1:0] w_y_next;
    logic signed [NB_DIFF-1:0] w_diff;
    logic signed [NB_DATA-1:0] w_err_next;

    assign w_sum      = NB_SUM'(r_p0) + NB_SUM'(r_p1) + NB_SUM'(r_p2);
    assign w_y_next   = f_sat(w_sum);
    assign w_diff     = NB_DIFF'(r_d1) - NB_DIFF'(w_y_next);
    assign w_err_next = f_sat(NB_SUM'(w_diff));

    // A flush drops the sample sitting in stage 1 as well, so the strobe is
    // cleared while the data outputs keep their last values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_y     <= '0;
            o_error <= '0;
            o_x0    <= '0;
            o_x1    <= '0;
            o_x2    <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else begin
            o_valid <= r_v1;
            o_y     <= w_y_next;
            o_error <= w_err_next;
            o_x0    <= r_s0;
            o_x1    <= r_s1;
            o_x2    <= r_s2;
        end
    end

endmodule

// File: tb/tb_adaptive_fir.sv
// Self-checking bench for adaptive_fir: directed cases plus randomized traffic
// compared each cycle against a sample-queue reference model.
module tb_adaptive_fir;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] x = '0, d = '0, h0 = '0, h1 = '0, h2 = '0;
    logic [15:0] nh0 = '0, nh1 = '0, nh2 = '0;
    logic        o_valid;
    logic [15:0] o_y, o_error, o_x0, o_x1, o_x2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulse_cnt = 0;
    int obs_y[$], obs_err[$], obs_x0[$], obs_x1[$], obs_x2[$], obs_cyc[$];

    adaptive_fir #(.NB_DATA(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_flush(flush),
        .i_x(x), .i_d(d), .i_h0(h0), .i_h1(h1), .i_h2(h2),
        .o_valid(o_valid), .o_y(o_y), .o_error(o_error),
        .o_x0(o_x0), .o_x1(o_x1), .o_x2(o_x2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    function automatic int clamp(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Q1.15 product, floor((h*x)/2^15), saturated
    function automatic int mprod(input int hv, input int xv);
        longint p, q;
        p = longint'(hv) * longint'(xv);
        q = p / 32768;
        if (p < 0 && (p % 32768) != 0) q = q - 1;
        return clamp(int'(q));
    endfunction

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -999999;
    endfunction

    // Reference model: each sample after warm-up becomes an in-flight entry that
    // picks up the coefficients one edge after acceptance and emits one edge later.
    typedef struct {
        int x0, x1, x2, d, y, err, age;
    } flight_t;

    flight_t fq[$];
    int  mx0 = 0, mx1 = 0, mx2 = 0, mfill = 0;
    bit  exp_valid = 1'b0;
    int  ey = 0, ee = 0, ex0 = 0, ex1 = 0, ex2 = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            fq.delete();
            mx0 = 0; mx1 = 0; mx2 = 0; mfill = 0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = 1'b0;
            foreach (fq[i]) begin
                fq[i].age++;
                if (fq[i].age == 1) begin
                    fq[i].y   = clamp(mprod(s16(h0), fq[i].x0) + mprod(s16(h1), fq[i].x1)
                                      + mprod(s16(h2), fq[i].x2));
                    fq[i].err = clamp(fq[i].d - fq[i].y);
                end
            end
            if (fq.size() > 0 && fq[0].age == 2) begin
                flight_t f;
                f = fq.pop_front();
                exp_valid = 1'b1;
                ey = f.y; ee = f.err; ex0 = f.x0; ex1 = f.x1; ex2 = f.x2;
            end
            if (valid) begin
                mx2 = mx1; mx1 = mx0; mx0 = s16(x);
                mfill = (mfill < 3) ? mfill + 1 : 3;
                if (mfill == 3) fq.push_back('{mx0, mx1, mx2, s16(d), 0, 0, 0});
            end
        end
    end

    // Compare process: outputs sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid", int'(o_valid), 0);
            check("rst_y",     s16(o_y), 0);
            check("rst_error", s16(o_error), 0);
            check("rst_x0",    s16(o_x0), 0);
            check("rst_x1",    s16(o_x1), 0);
            check("rst_x2",    s16(o_x2), 0);
        end else begin
            check("valid", int'(o_valid), int'(exp_valid));
            if (exp_valid) begin
                check("y",     s16(o_y), ey);
                check("error", s16(o_error), ee);
                check("x0",    s16(o_x0), ex0);
                check("x1",    s16(o_x1), ex1);
                check("x2",    s16(o_x2), ex2);
            end
            if (o_valid) begin
                pulse_cnt++;
                obs_y.push_back(s16(o_y));
                obs_err.push_back(s16(o_error));
                obs_x0.push_back(s16(o_x0));
                obs_x1.push_back(s16(o_x1));
                obs_x2.push_back(s16(o_x2));
                obs_cyc.push_back(cyc);
            end
        end
    end

    function automatic logic [15:0] rnd_word();
        case ($urandom_range(0, 5))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic set_h(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        nh0 = a; nh1 = b; nh2 = c;
    endtask

    task automatic drive(input bit v, input bit f, input logic [15:0] xv, input logic [15:0] dv);
        @(negedge clk);
        valid = v; flush = f; x = xv; d = dv;
        h0 = nh0; h1 = nh1; h2 = nh2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        pulse_cnt = 0;
        obs_y.delete(); obs_err.delete(); obs_x0.delete();
        obs_x1.delete(); obs_x2.delete(); obs_cyc.delete();
    endtask

    task automatic fresh_start();
        idle(4);
        settle();
        clear_obs();
        drive(1'b0, 1'b1, 16'h0, 16'h0);
    endtask

    int acc_cyc;

    initial begin
        // Model pins against hand-computed products
        check("model_minmin", mprod(-32768, -32768), 32767);
        check("model_floor",  mprod(-1, 1), -1);
        check("model_maxmax", mprod(32767, 32767), 32766);

        // Reset held with live traffic, then release
        for (int i = 0; i < 5; i++) begin
            set_h(rnd_word(), rnd_word(), rnd_word());
            drive(1'b1, 1'b0, rnd_word(), rnd_word());
        end
        rst_n = 1'b1;
        clear_obs();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, rnd_word(), rnd_word());
        settle();
        check("post_reset_quiet", pulse_cnt, 0);

        // Impulse response
        fresh_start();
        set_h(16'h4000, 16'h2000, 16'h1000);
        drive(1'b1, 1'b0, 16'h0000, 16'h0);
        drive(1'b1, 1'b0, 16'h0000, 16'h0);
        drive(1'b1, 1'b0, 16'h4000, 16'h0);
        acc_cyc = cyc + 1;
        drive(1'b1, 1'b0, 16'h0000, 16'h0);
        drive(1'b1, 1'b0, 16'h0000, 16'h0);
        idle(4);
        settle();
        check("imp_pulses", pulse_cnt, 3);
        check("imp_y0",   qat(obs_y, 0), s16(16'h2000));
        check("imp_y1",   qat(obs_y, 1), s16(16'h1000));
        check("imp_y2",   qat(obs_y, 2), s16(16'h0800));
        check("imp_e0",   qat(obs_err, 0), s16(16'hE000));
        check("imp_e1",   qat(obs_err, 1), s16(16'hF000));
        check("imp_e2",   qat(obs_err, 2), s16(16'hF800));
        check("imp_x0_0", qat(obs_x0, 0), s16(16'h4000));
        check("imp_x1_1", qat(obs_x1, 1), s16(16'h4000));
        check("imp_x2_2", qat(obs_x2, 2), s16(16'h4000));
        // Visible two edges after the accepting edge, i.e. cycle n+3
        check("imp_latency", qat(obs_cyc, 0) - acc_cyc, 2);

        // Saturation, positive full scale
        fresh_start();
        set_h(16'h7FFF, 16'h7FFF, 16'h7FFF);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 16'h7FFF, 16'h8000);
        idle(4);
        settle();
        check("sat_pulses", pulse_cnt, 2);
        check("sat_y",      qat(obs_y, 1), s16(16'h7FFF));
        check("sat_err",    qat(obs_err, 1), s16(16'h8000));

        // Saturation, -1.0 * -1.0
        fresh_start();
        set_h(16'h8000, 16'h0000, 16'h0000);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 16'h8000, 16'h0000);
        idle(4);
        settle();
        check("minmin_y",   qat(obs_y, 0), s16(16'h7FFF));
        check("minmin_err", qat(obs_err, 0), s16(16'h8001));

        // Gapped input: 20 samples with random gaps and coefficients
        fresh_start();
        for (int n = 0; n < 20; ) begin
            set_h(rnd_word(), rnd_word(), rnd_word());
            if ($urandom_range(0, 2) == 0) begin
                drive(1'b0, 1'b0, rnd_word(), rnd_word());
            end else begin
                drive(1'b1, 1'b0, rnd_word(), rnd_word());
                n++;
            end
        end
        idle(4);
        settle();
        check("gap_pulses", pulse_cnt, 18);

        // Flush one cycle after an accepted sample
        fresh_start();
        set_h(16'h4000, 16'h4000, 16'h4000);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, rnd_word(), rnd_word());
        idle(4);
        settle();
        clear_obs();
        drive(1'b1, 1'b0, 16'h7FFF, 16'h0);
        drive(1'b0, 1'b1, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 16'h1000, 16'h0);
        drive(1'b1, 1'b0, 16'h2000, 16'h0);
        drive(1'b1, 1'b0, 16'h0800, 16'h0);
        idle(4);
        settle();
        check("flush_pulses", pulse_cnt, 1);
        check("flush_y",      qat(obs_y, 0), s16(16'h1C00));
        check("flush_err",    qat(obs_err, 0), s16(16'hE400));
        check("flush_x2",     qat(obs_x2, 0), s16(16'h1000));

        // Flush together with valid: sample discarded
        clear_obs();
        drive(1'b1, 1'b1, 16'h7FFF, 16'h0);
        drive(1'b1, 1'b0, 16'h1000, 16'h0);
        drive(1'b1, 1'b0, 16'h2000, 16'h0);
        drive(1'b1, 1'b0, 16'h0800, 16'h0);
        idle(4);
        settle();
        check("flushvalid_pulses", pulse_cnt, 1);
        check("flushvalid_y",      qat(obs_y, 0), s16(16'h1C00));

        // Random soak with occasional flushes
        for (int i = 0; i < 300; i++) begin
            set_h(rnd_word(), rnd_word(), rnd_word());
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, rnd_word(), rnd_word());
        end

        // Async reset in the middle of a back-to-back burst
        fresh_start();
        for (int i = 0; i < 10; i++) begin
            set_h(rnd_word(), rnd_word(), rnd_word());
            drive(1'b1, 1'b0, rnd_word(), rnd_word());
        end
        @(posedge clk);
        #1;
        check("burst_active", int'(o_valid), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_valid", int'(o_valid), 0);
        check("async_y",     s16(o_y), 0);
        check("async_error", s16(o_error), 0);
        check("async_x0",    s16(o_x0), 0);
        clear_obs();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, rnd_word(), rnd_word());
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_h(rnd_word(), rnd_word(), rnd_word());
            drive(1'b1, 1'b0, rnd_word(), rnd_word());
        end
        idle(4);
        settle();
        check("post_async_pulses", pulse_cnt, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
